// File: rtl/bitcnt_pkg.sv
// Shared definitions for the bit-count arbiter: op encoding, result width,
// FSM states and the bit-smear helper used for leading-zero counting.
package bitcnt_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_CPOP = 2'b00,
    OP_CTZ  = 2'b01,
    OP_CLZ  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Copies every set bit into all lower positions; ~result marks the leading zeros.
  function automatic logic [31:0] smear_right(input logic [31:0] x);
    logic [31:0] s;
    s = x;
    s = s | (s >> 1);
    s = s | (s >> 2);
    s = s | (s >> 4);
    s = s | (s >> 8);
    s = s | (s >> 16);
    return s;
  endfunction

endpackage

// File: rtl/bitcnt_arbiter_popcount.sv
// Combinational 32-bit population count, result 0..32.
module bitcnt_arbiter_popcount
  import bitcnt_pkg::*;
(
  input  logic [31:0]      x_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_o = cnt_o + CNT_W'(x_i[i]);
    end
  end

endmodule

// File: rtl/bitcnt_arbiter.sv
// Two-requester arbiter sharing one popcount datapath (CPOP/CTZ/CLZ), with a
// single-entry EMPTY/FULL output register and round-robin or fixed priority.
module bitcnt_arbiter
  import bitcnt_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [31:0]      r0_x,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [31:0]      r1_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_res,
  output logic             out_src,
  output logic             out_illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             src_q, src_d;
  logic             ill_q, ill_d;
  logic             last_q, last_d;

  logic             grant0, grant1, can_accept, accept, sel;
  logic [1:0]       op_sel;
  logic [31:0]      x_sel, pc_in;
  logic [CNT_W-1:0] pc_cnt;

  // last_q==1 means port 1 was served last, so port 0 wins the next tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (r0_valid && r1_valid) begin
      if (RR_EN) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = r0_valid;
      grant1 = r1_valid;
    end
  end

  assign can_accept = (state_q == ST_EMPTY) | out_ready;
  assign accept     = can_accept & (grant0 | grant1);
  assign r0_ready   = can_accept & grant0;
  assign r1_ready   = can_accept & grant1;

  assign sel    = grant1;
  assign op_sel = sel ? r1_op : r0_op;
  assign x_sel  = sel ? r1_x  : r0_x;

  // Every op reduces to a popcount of a transformed operand; reserved yields 0.
  always_comb begin
    pc_in = '0;
    case (op_e'(op_sel))
      OP_CPOP: pc_in = x_sel;
      OP_CTZ:  pc_in = ~x_sel & (x_sel - 32'd1);
      OP_CLZ:  pc_in = ~smear_right(x_sel);
      default: pc_in = '0;
    endcase
  end

  bitcnt_arbiter_popcount u_popcount (
    .x_i   (pc_in),
    .cnt_o (pc_cnt)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    src_d   = src_q;
    ill_d   = ill_q;
    last_d  = last_q;
    if (accept) begin
      state_d = ST_FULL;
      res_d   = pc_cnt;
      src_d   = sel;
      ill_d   = (op_e'(op_sel) == OP_RSVD);
      last_d  = sel;
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      src_q   <= 1'b0;
      ill_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      src_q   <= src_d;
      ill_q   <= ill_d;
      last_q  <= last_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_res     = res_q;
  assign out_src     = src_q;
  assign out_illegal = ill_q;

endmodule
